estacao_vedacao: RTL and testbench

Cork-capping station controller for the bottling line. It debounces the capping-position bottle sensor, stops the conveyor, and drives the capping actuator for a fixed time. It keeps the cork stock count and emits a one-cycle `garrafa_vedada` pulse per sealed bottle. That pulse is the `incrementar` input of the downstream dozen counter.

---
 rtl/estacao_vedacao.sv | 174 +++++++++++++++++
 tb/tb_estacao_vedacao.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estacao_vedacao.sv
// Cork-capping station controller: debounce bottle sensor, stop conveyor, cap, count corks.
// Latency: sensor rise before edge E -> vedar high after E+2+DEBOUNCE; vedar holds T_VEDACAO cycles.
// Backpressure: none; level inputs are sampled every cycle and garrafa_vedada is a fire-and-forget pulse.
//
// Ports:
//   clk, reset          50 MHz clock, asynchronous active-high reset
//   habilitar           line running (synchronous level)
//   sensor_vedacao      raw asynchronous bottle-present sensor
//   repor_rolhas        refill button (synchronous level, rising edge = one refill)
//   vedar               capping actuator (registered)
//   motor_parar         conveyor stop request (registered)
//   garrafa_vedada      one-cycle pulse per sealed bottle (registered)
//   rolhas_estoque      cork stock 0..ROLHAS_MAX (registered)
//   alarme_rolhas       stock below ALERTA_MIN
//   sem_rolha           FSM waiting for a refill with a bottle in position
module estacao_vedacao #(
  parameter int unsigned T_VEDACAO      = 50_000_000,
  parameter int unsigned DEBOUNCE       = 500_000,
  parameter logic [6:0]  ROLHAS_INICIAL = 7'd20,
  parameter logic [6:0]  REPOSICAO      = 7'd15,
  parameter logic [6:0]  ROLHAS_MAX     = 7'd99,
  parameter logic [6:0]  ALERTA_MIN     = 7'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       sensor_vedacao,
  input  logic       repor_rolhas,
  output logic       vedar,
  output logic       motor_parar,
  output logic       garrafa_vedada,
  output logic [6:0] rolhas_estoque,
  output logic       alarme_rolhas,
  output logic       sem_rolha
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    VEDANDO   = 2'd1,
    LIBERANDO = 2'd2,
    SEM_ROLHA = 2'd3
  } estado_t;

  localparam logic [19:0] DEB_LIM = 20'(DEBOUNCE);
  localparam logic [25:0] T_FIM   = 26'(T_VEDACAO - 1);

  estado_t     estado_q, estado_d;
  logic        sync1_q, sync1_d;
  logic        s_sync_q, s_sync_d;
  logic        s_filt_q, s_filt_d;
  logic        s_filt_dly_q, s_filt_dly_d;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic        repor_dly_q, repor_dly_d;
  logic [25:0] timer_q, timer_d;
  logic [6:0]  rolhas_q, rolhas_d;
  logic        vedar_q, vedar_d;
  logic        motor_parar_q, motor_parar_d;
  logic        garrafa_q, garrafa_d;

  logic        chegada;
  logic        rep;
  logic        dec;
  logic        tem_rolha;
  logic [7:0]  soma;

  always_comb begin
    // Input conditioning
    sync1_d      = sensor_vedacao;
    s_sync_d     = sync1_q;
    s_filt_d     = s_filt_q;
    deb_cnt_d    = '0;
    if (s_sync_q != s_filt_q) begin
      // The edge that would make the count reach DEBOUNCE accepts the new level instead.
      if (deb_cnt_q + 20'd1 == DEB_LIM) begin
        s_filt_d  = s_sync_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 20'd1;
      end
    end
    s_filt_dly_d = s_filt_q;
    chegada      = s_filt_q & ~s_filt_dly_q;
    repor_dly_d  = repor_rolhas;
    rep          = repor_rolhas & ~repor_dly_q;
    tem_rolha    = (rolhas_q != 7'd0);

    // FSM next state
    estado_d  = estado_q;
    timer_d   = timer_q;
    dec       = 1'b0;
    garrafa_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        // An arrival while the line is stopped is dropped, not remembered.
        if (chegada && habilitar) begin
          if (tem_rolha) begin
            estado_d = VEDANDO;
            timer_d  = '0;
          end else begin
            estado_d = SEM_ROLHA;
          end
        end
      end
      VEDANDO: begin
        if (timer_q == T_FIM) begin
          estado_d  = LIBERANDO;
          dec       = tem_rolha;
          garrafa_d = 1'b1;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      LIBERANDO: begin
        if (!s_filt_q) estado_d = OCIOSO;
      end
      SEM_ROLHA: begin
        // Bottle is still under the capper, so go straight to capping once stocked.
        if (tem_rolha) begin
          estado_d = VEDANDO;
          timer_d  = '0;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Registered outputs follow the state being entered
    vedar_d = (estado_d == VEDANDO);
    if (estado_d == OCIOSO || estado_d == LIBERANDO) motor_parar_d = ~habilitar;
    else                                             motor_parar_d = 1'b1;

    // Stock: refill and decrement may coincide; compute at 8 bits then clamp.
    soma = {1'b0, rolhas_q} + (rep ? {1'b0, REPOSICAO} : 8'd0) - {7'd0, dec};
    if (soma > {1'b0, ROLHAS_MAX}) rolhas_d = ROLHAS_MAX;
    else                           rolhas_d = soma[6:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      sync1_q       <= 1'b0;
      s_sync_q      <= 1'b0;
      s_filt_q      <= 1'b0;
      s_filt_dly_q  <= 1'b0;
      deb_cnt_q     <= '0;
      repor_dly_q   <= 1'b0;
      timer_q       <= '0;
      rolhas_q      <= ROLHAS_INICIAL;
      vedar_q       <= 1'b0;
      motor_parar_q <= 1'b1;
      garrafa_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      sync1_q       <= sync1_d;
      s_sync_q      <= s_sync_d;
      s_filt_q      <= s_filt_d;
      s_filt_dly_q  <= s_filt_dly_d;
      deb_cnt_q     <= deb_cnt_d;
      repor_dly_q   <= repor_dly_d;
      timer_q       <= timer_d;
      rolhas_q      <= rolhas_d;
      vedar_q       <= vedar_d;
      motor_parar_q <= motor_parar_d;
      garrafa_q     <= garrafa_d;
    end
  end

  assign vedar          = vedar_q;
  assign motor_parar    = motor_parar_q;
  assign garrafa_vedada = garrafa_q;
  assign rolhas_estoque = rolhas_q;
  assign alarme_rolhas  = (rolhas_q < ALERTA_MIN);
  assign sem_rolha      = (estado_q == SEM_ROLHA);

endmodule

// File: tb/tb_estacao_vedacao.sv
// Testbench for estacao_vedacao with DEBOUNCE=4, T_VEDACAO=10, default stock parameters.
// Stimulus pushes the expected stock/alarm for each capping; a negedge monitor pops on every pulse.
// Direct checks cover reset state, latency, glitches, exhaustion, saturation, disable and reset.
module tb_estacao_vedacao;

  localparam int T_VED = 10;
  localparam int DEB   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       habilitar;
  logic       sensor_vedacao;
  logic       repor_rolhas;
  logic       vedar;
  logic       motor_parar;
  logic       garrafa_vedada;
  logic [6:0] rolhas_estoque;
  logic       alarme_rolhas;
  logic       sem_rolha;

  estacao_vedacao #(
    .T_VEDACAO(T_VED),
    .DEBOUNCE (DEB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .habilitar     (habilitar),
    .sensor_vedacao(sensor_vedacao),
    .repor_rolhas  (repor_rolhas),
    .vedar         (vedar),
    .motor_parar   (motor_parar),
    .garrafa_vedada(garrafa_vedada),
    .rolhas_estoque(rolhas_estoque),
    .alarme_rolhas (alarme_rolhas),
    .sem_rolha     (sem_rolha)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stock;
    int alarm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   model_stock;
  int   vlen;
  bit   prev_pulse;
  exp_t mon_e;
  bit   seen;

  task automatic chk(input string nome, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, req, $time);
    end
  endtask

  function automatic int prox(input int s, input bit add, input bit dec);
    int v;
    v = s + (add ? 15 : 0) - (dec ? 1 : 0);
    if (v > 99) v = 99;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cap(input bit with_refill);
    exp_t e;
    model_stock = prox(model_stock, with_refill, 1'b1);
    e.stock = model_stock;
    e.alarm = (model_stock < 5) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic bottle(input int hold, input int gap);
    sensor_vedacao = 1'b1;
    repeat (hold) tick();
    sensor_vedacao = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic refill();
    model_stock = prox(model_stock, 1'b1, 1'b0);
    repor_rolhas = 1'b1;
    tick();
    repor_rolhas = 1'b0;
    tick();
    chk("stock_after_refill", rolhas_estoque, model_stock);
  endtask

  task automatic watch(input int n, output bit any_vedar);
    any_vedar = 1'b0;
    repeat (n) begin
      tick();
      if (vedar) any_vedar = 1'b1;
    end
  endtask

  // Monitor: every garrafa_vedada pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      vlen       = 0;
      prev_pulse = 1'b0;
    end else begin
      if (vedar) vlen++;
      if (prev_pulse) chk("pulse_one_cycle", garrafa_vedada, 0);
      if (garrafa_vedada) begin
        n_pulses++;
        chk("pulse_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("pulse_stock", rolhas_estoque, mon_e.stock);
          chk("pulse_alarm", alarme_rolhas, mon_e.alarm);
          chk("vedar_length", vlen, T_VED);
          chk("pulse_vedar_low", vedar, 0);
        end
        vlen = 0;
      end
      prev_pulse = garrafa_vedada;
    end
  end

  initial begin
    reset          = 1'b1;
    habilitar      = 1'b0;
    sensor_vedacao = 1'b0;
    repor_rolhas   = 1'b0;
    model_stock    = 20;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vedar", vedar, 0);
    chk("rst_motor_parar", motor_parar, 1);
    chk("rst_garrafa", garrafa_vedada, 0);
    chk("rst_stock", rolhas_estoque, 20);
    chk("rst_alarm", alarme_rolhas, 0);
    chk("rst_sem_rolha", sem_rolha, 0);

    reset     = 1'b0;
    habilitar = 1'b1;
    chk("motor_before_edge", motor_parar, 1);
    tick();
    chk("motor_release", motor_parar, 0);
    repeat (3) tick();

    // Normal cycle with detailed latency checks
    expect_cap(1'b0);
    sensor_vedacao = 1'b1;
    repeat (6) tick();
    chk("vedar_not_yet", vedar, 0);
    tick();
    chk("vedar_rise", vedar, 1);
    chk("motor_stop_capping", motor_parar, 1);
    repeat (9) tick();
    chk("vedar_last_cycle", vedar, 1);
    tick();
    chk("vedar_fall", vedar, 0);
    chk("pulse_on_fall", garrafa_vedada, 1);
    chk("motor_release_on_fall", motor_parar, 0);
    chk("stock_19", rolhas_estoque, 19);
    repeat (13) tick();
    sensor_vedacao = 1'b0;
    repeat (10) tick();

    // Glitch rejection
    seen = 1'b0;
    for (int g = 0; g < 3; g++) begin
      bit s;
      sensor_vedacao = 1'b1;
      repeat (3) tick();
      sensor_vedacao = 1'b0;
      watch(10, s);
      if (s || vedar) seen = 1'b1;
    end
    chk("glitch_no_vedar", seen, 0);
    chk("glitch_stock", rolhas_estoque, 19);

    // Eleven more bottles: twelve in total, 20 -> 8
    for (int b = 0; b < 11; b++) begin
      expect_cap(1'b0);
      bottle(30, 10);
    end
    chk("twelve_pulses", n_pulses, 12);
    chk("stock_8", rolhas_estoque, 8);
    chk("alarm_at_8", alarme_rolhas, 0);

    // Run the stock down to zero
    for (int b = 0; b < 8; b++) begin
      expect_cap(1'b0);
      bottle(30, 10);
    end
    chk("stock_0", rolhas_estoque, 0);
    chk("alarm_at_0", alarme_rolhas, 1);

    // Exhaustion: bottle waits in SEM_ROLHA until a refill
    sensor_vedacao = 1'b1;
    repeat (7) tick();
    chk("sem_rolha_set", sem_rolha, 1);
    chk("sem_motor", motor_parar, 1);
    chk("sem_vedar", vedar, 0);
    chk("sem_alarm", alarme_rolhas, 1);
    model_stock = prox(model_stock, 1'b1, 1'b0);
    expect_cap(1'b0);
    repor_rolhas = 1'b1;
    tick();
    repor_rolhas = 1'b0;
    chk("refill_stock_15", rolhas_estoque, 15);
    chk("still_sem_rolha", sem_rolha, 1);
    tick();
    chk("vedando_after_refill", vedar, 1);
    chk("sem_rolha_clear", sem_rolha, 0);
    repeat (20) tick();
    sensor_vedacao = 1'b0;
    repeat (10) tick();
    chk("stock_14", rolhas_estoque, 14);

    // Down to 10, then refill on the decrement edge -> 24
    for (int b = 0; b < 4; b++) begin
      expect_cap(1'b0);
      bottle(30, 10);
    end
    chk("stock_10", rolhas_estoque, 10);
    expect_cap(1'b1);
    sensor_vedacao = 1'b1;
    repeat (16) tick();
    repor_rolhas = 1'b1;
    tick();
    repor_rolhas = 1'b0;
    chk("simultaneous_24", rolhas_estoque, 24);
    repeat (14) tick();
    sensor_vedacao = 1'b0;
    repeat (10) tick();

    // 24 -> 15 -> 90 -> 99 saturated
    for (int b = 0; b < 9; b++) begin
      expect_cap(1'b0);
      bottle(30, 10);
    end
    for (int r = 0; r < 5; r++) refill();
    chk("stock_90", rolhas_estoque, 90);
    refill();
    chk("saturate_99", rolhas_estoque, 99);

    // Line disabled while idle: arrival ignored
    habilitar = 1'b0;
    tick();
    chk("disabled_motor", motor_parar, 1);
    sensor_vedacao = 1'b1;
    watch(30, seen);
    chk("disabled_no_vedar", seen, 0);
    sensor_vedacao = 1'b0;
    repeat (10) tick();
    habilitar = 1'b1;
    tick();
    chk("reenabled_motor", motor_parar, 0);
    chk("disabled_stock", rolhas_estoque, 99);

    // Line disabled mid-capping: capping completes
    expect_cap(1'b0);
    sensor_vedacao = 1'b1;
    repeat (10) tick();
    chk("midcap_vedar", vedar, 1);
    habilitar = 1'b0;
    repeat (10) tick();
    chk("midcap_stock", rolhas_estoque, 98);
    chk("midcap_motor_liberando", motor_parar, 1);
    sensor_vedacao = 1'b0;
    repeat (10) tick();
    habilitar = 1'b1;
    tick();

    // Reset mid-capping: vedar drops at once, stock reloads, no pulse
    sensor_vedacao = 1'b1;
    repeat (10) tick();
    chk("prereset_vedar", vedar, 1);
    reset = 1'b1;
    #2;
    chk("reset_vedar_async", vedar, 0);
    chk("reset_stock", rolhas_estoque, 20);
    chk("reset_garrafa", garrafa_vedada, 0);
    model_stock = 20;
    sensor_vedacao = 1'b0;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_reset_stock", rolhas_estoque, 20);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
